mmac_tile_sequencer: RTL and testbench
======================================

// Module: mmac_tile_sequencer
// PURPOSE
//  Job controller for the 4x4 matrix multiply/accumulate datapath (mmac_pkg sizes).
//  Gathers A/B elements from a valid/ready stream and packs them into one tile.
//  Issues each tile to the datapath and sums NUM_TILES products lane-wise.
//  Returns the result matrix through a valid/ready output.
// PARAMETERS
//  MAC_LAT    2  cycles from mac_enable sample to mac_res valid; legal range 1..15
//  TILE_CW    8  width of the num_tiles job field
// PORTS
//  clk        in   1            clock
//  rst        in   1            reset: synchronous, active-low
//  start      in   1            job request; accepted only in IDLE
//  num_tiles  in   TILE_CW      tiles to accumulate; latched on accept; 0 is treated as 1
//  in_valid   in   1            element pair valid
//  in_ready   out  1            element pair accepted when in_valid & in_ready
//  in_a       in   VAR_WIDTH    A element, row-major order
//  in_b       in   VAR_WIDTH    B element, row-major order
//  mac_a      out  DATA_WIDTH   packed A tile to datapath
//  mac_b      out  DATA_WIDTH   packed B tile to datapath
//  mac_enable out  1            one-cycle issue strobe
//  mac_clear  out  1            one-cycle datapath accumulator clear
//  mac_res    in   DATA_WIDTH   packed product tile from datapath
//  out_valid  out  1            result valid; held until accepted
//  out_ready  in   1            result sink ready
//  out_data   out  DATA_WIDTH   packed accumulated result
//  busy       out  1            high in every state except IDLE
//  done       out  1            one-cycle pulse on the out_valid & out_ready handshake
// BEHAVIOUR
//  Packing: element (r,c) uses index idx=r*M_SIZE+c at bits [idx*VAR_WIDTH +: VAR_WIDTH]; idx 0 is the LSB.
//  Reset (rst==0 at posedge): state=IDLE; every output, element counter, tile counter and acc register is 0.
//  FSM: IDLE -> CLR -> LOAD -> ISSUE -> WAIT -> ACC -> (LOAD | OUT) -> IDLE.
//  IDLE: in_ready=0. start=1 latches num_tiles (0 becomes 1), zeroes acc, and moves to CLR.
//  CLR: mac_clear=1 for exactly 1 cycle, then LOAD.
//  LOAD: in_ready=1. Each handshake writes in_a/in_b into lane idx and increments idx.
//   The 16th handshake (idx=15) moves to ISSUE; idx wraps to 0.
//  ISSUE: mac_enable=1 for 1 cycle. mac_a/mac_b stay stable from ISSUE until ACC exits.
//  WAIT: counts MAC_LAT-1 cycles. mac_res is sampled on the MAC_LAT-th cycle after ISSUE, in state ACC.
//  ACC: acc[lane] += mac_res[lane] for all 16 lanes in parallel; lane width is VAR_WIDTH, wraps mod 2^VAR_WIDTH.
//   tile_cnt increments. If tile_cnt==num_tiles go to OUT, else go to LOAD.
//  OUT: out_valid=1 and out_data=acc, both held stable until out_ready. On the handshake: done=1, go to IDLE.
//  Job latency with no stalls: 1 accept + 1 CLR + per tile (16 LOAD + 1 ISSUE + MAC_LAT) + 1 OUT cycles.
//  start while busy is ignored, not queued. in_valid outside LOAD is ignored (in_ready=0).
//  out_ready held high: the result is taken in the first OUT cycle, so done follows in that same cycle.
//  Reset mid-job aborts immediately: partial tiles and acc are discarded, and no done is issued.
// CONFIGURATION
//  MMAC_SAT_EN defined: the ACC lane add saturates as unsigned at 2^VAR_WIDTH-1.
//   It also sets sticky output sat_flag (1 bit), which is cleared on job accept.
//  MMAC_SAT_EN undefined: the lane add wraps, and the sat_flag port does not exist.
// STRUCTURE
//  mmac_pkg gains: typedef enum logic [2:0] mmac_seq_state_t {IDLE,CLR,LOAD,ISSUE,WAIT,ACC,OUT};
//   localparam ELEMS = M_SIZE*M_SIZE; function lane_add(a,b) (wrap/saturate per macro).
//  Reuse DATA_WIDTH, VAR_WIDTH, M_SIZE from mmac_pkg; no local redefinition.
//  One sub-module: mmac_tile_packer. It holds the element counter and the A/B lane registers.
//   It provides a load/full interface, so the FSM and accumulator stay in the top level.
// TESTING
//  1 Single tile, A=identity, B all lanes 3, num_tiles=1.
//    -> out_data all lanes 3; one done pulse; in_ready low outside LOAD.
//  2 num_tiles=2; tile0 A=I,B=all 1; tile1 A=I,B=all 2.
//    -> out_data all lanes 3; exactly 2 mac_enable pulses; 1 mac_clear pulse.
//  3 Random in_valid gaps (50%) plus out_ready low for 5 cycles in OUT.
//    -> result unchanged; out_data stable while stalled; done only on handshake.
//  4 rst low after 7 LOAD handshakes, then a new job with A=I, B=all 5.
//    -> all outputs 0 during reset; new result all lanes 5.
//  5 num_tiles=0 and start pulsed while busy.
//    -> behaves as 1 tile; the second start is ignored; done count = 1.
//  6 MMAC_SAT_EN, VAR_WIDTH=8, 2 tiles each producing 200 per lane.
//    -> lanes 255, sat_flag=1. Without the macro -> lanes 144.

Source files
------------

// File: rtl/mmac_pkg.sv
// Shared sizes, sequencer state type and lane arithmetic for the 4x4 MMAC.
// MMAC_SAT_EN selects saturating lane adds instead of wrapping ones.
package mmac_pkg;

  localparam int M_SIZE     = 4;
  localparam int VAR_WIDTH  = 8;
  localparam int ELEMS      = M_SIZE * M_SIZE;
  localparam int DATA_WIDTH = ELEMS * VAR_WIDTH;
  localparam int IDX_W      = $clog2(ELEMS);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    ISSUE,
    WAIT,
    ACC,
    OUT
  } mmac_seq_state_t;

  function automatic logic [VAR_WIDTH-1:0] lane_add(
    input logic [VAR_WIDTH-1:0] a,
    input logic [VAR_WIDTH-1:0] b
  );
    logic [VAR_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef MMAC_SAT_EN
    lane_add = s[VAR_WIDTH] ? '1 : s[VAR_WIDTH-1:0];
`else
    lane_add = s[VAR_WIDTH-1:0];
`endif
  endfunction

  function automatic logic lane_ovf(
    input logic [VAR_WIDTH-1:0] a,
    input logic [VAR_WIDTH-1:0] b
  );
    logic [VAR_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    lane_ovf = s[VAR_WIDTH];
  endfunction

endpackage

// File: rtl/mmac_tile_packer.sv
// Element counter and A/B lane registers for one 4x4 tile.
// o_full flags the load that completes the tile; the counter then wraps.
module mmac_tile_packer
  import mmac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [VAR_WIDTH-1:0]  i_a,
  input  logic [VAR_WIDTH-1:0]  i_b,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ELEMS - 1);

  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_a[r_idx*VAR_WIDTH +: VAR_WIDTH] <= i_a;
      r_b[r_idx*VAR_WIDTH +: VAR_WIDTH] <= i_b;
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_full = i_load && (r_idx == LAST);
  assign o_a    = r_a;
  assign o_b    = r_b;

endmodule

// File: rtl/mmac_tile_sequencer.sv
// Job controller: packs tiles, issues them to the MMAC datapath, sums results.
// Define MMAC_SAT_EN for saturating accumulation and the sat_flag output.
module mmac_tile_sequencer
  import mmac_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int TILE_CW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_CW-1:0]    num_tiles,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VAR_WIDTH-1:0]  in_a,
  input  logic [VAR_WIDTH-1:0]  in_b,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_enable,
  output logic                  mac_clear,
  input  logic [DATA_WIDTH-1:0] mac_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef MMAC_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(MAC_LAT - 2);

  mmac_seq_state_t       r_state;
  mmac_seq_state_t       w_next;
  logic [TILE_CW-1:0]    r_num_tiles;
  logic [TILE_CW-1:0]    r_tile_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [3:0]            r_wait;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_full;
  logic                  w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_load   = in_valid && in_ready;
  assign w_last   = (TILE_CW'(r_tile_cnt + 1'b1) == r_num_tiles);

  mmac_tile_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_load (w_load),
    .i_a    (in_a),
    .i_b    (in_b),
    .o_full (w_full),
    .o_a    (mac_a),
    .o_b    (mac_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    mac_enable = 1'b0;
    mac_clear  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = CLR;
      end
      CLR: begin
        mac_clear = 1'b1;
        w_next    = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (w_full) w_next = ISSUE;
      end
      ISSUE: begin
        mac_enable = 1'b1;
        w_next     = (MAC_LAT == 1) ? ACC : WAIT;
      end
      WAIT: begin
        if (r_wait == WAIT_LAST) w_next = ACC;
      end
      ACC: begin
        w_next = w_last ? OUT : LOAD;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sum = r_acc;
    for (int i = 0; i < ELEMS; i++) begin
      w_sum[i*VAR_WIDTH +: VAR_WIDTH] =
        lane_add(r_acc[i*VAR_WIDTH +: VAR_WIDTH],
                 mac_res[i*VAR_WIDTH +: VAR_WIDTH]);
    end
  end

  // mac_res is only meaningful in ACC, MAC_LAT cycles after the issue strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_num_tiles <= '0;
      r_tile_cnt  <= '0;
      r_acc       <= '0;
      r_wait      <= '0;
    end else begin
      r_wait <= (r_state == WAIT) ? r_wait + 1'b1 : '0;
      if (w_accept) begin
        r_num_tiles <= (num_tiles == '0) ? TILE_CW'(1) : num_tiles;
        r_tile_cnt  <= '0;
        r_acc       <= '0;
      end else if (r_state == ACC) begin
        r_acc      <= w_sum;
        r_tile_cnt <= r_tile_cnt + 1'b1;
      end
    end
  end

  assign out_data = r_acc;

`ifdef MMAC_SAT_EN
  logic w_ovf;
  logic r_sat;

  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < ELEMS; i++) begin
      w_ovf = w_ovf |
        lane_ovf(r_acc[i*VAR_WIDTH +: VAR_WIDTH],
                 mac_res[i*VAR_WIDTH +: VAR_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                   r_sat <= 1'b0;
    else if (w_accept)          r_sat <= 1'b0;
    else if (r_state == ACC)    r_sat <= r_sat | w_ovf;
  end

  assign sat_flag = r_sat;
`endif

endmodule

// File: tb/tb_mmac_tile_sequencer.sv
// Bench for mmac_tile_sequencer: job table plus reset-abort sequence,
// with a delayed-product datapath stand-in and a matrix-level reference.
module tb_mmac_tile_sequencer;
  import mmac_pkg::*;

  localparam int MAC_LAT = 2;
  localparam int TILE_CW = 8;
  localparam int DW      = DATA_WIDTH;
  localparam int VW      = VAR_WIDTH;
  localparam int VMAX    = (1 << VW) - 1;

  typedef struct {
    int ntf;
    int akind;
    int bval;
    int bstep;
    int gap;
    int stall;
    int bstart;
    int exp_lane;
  } vec_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic [TILE_CW-1:0] num_tiles;
  logic               in_valid;
  logic               in_ready;
  logic [VW-1:0]      in_a;
  logic [VW-1:0]      in_b;
  logic [DW-1:0]      mac_a;
  logic [DW-1:0]      mac_b;
  logic               mac_enable;
  logic               mac_clear;
  logic [DW-1:0]      mac_res;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               busy;
  logic               done;
`ifdef MMAC_SAT_EN
  logic               sat_flag;
`endif

  int nvec;
  int nerr;
  int n_en, n_clr, n_done, n_hs, n_perr;
  int ma[4][ELEMS];
  int mb[4][ELEMS];
  logic [DW-1:0] pipe [MAC_LAT];

  mmac_tile_sequencer #(
    .MAC_LAT (MAC_LAT),
    .TILE_CW (TILE_CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_tiles  (num_tiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_enable (mac_enable),
    .mac_clear  (mac_clear),
    .mac_res    (mac_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
`ifdef MMAC_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] dp_mul(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] p;
    int s;
    p = '0;
    for (int r = 0; r < M_SIZE; r++)
      for (int c = 0; c < M_SIZE; c++) begin
        s = 0;
        for (int k = 0; k < M_SIZE; k++)
          s += int'(a[(r*M_SIZE+k)*VW +: VW]) * int'(b[(k*M_SIZE+c)*VW +: VW]);
        p[(r*M_SIZE+c)*VW +: VW] = VW'(s);
      end
    return p;
  endfunction

  // Datapath stand-in: product valid exactly MAC_LAT cycles after the strobe
  always @(posedge clk) begin
    for (int i = MAC_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mac_enable ? dp_mul(mac_a, mac_b)
                          : {$urandom(), $urandom(), $urandom(), $urandom()};
  end
  assign mac_res = pipe[MAC_LAT-1];

  always @(negedge clk) begin
    if (rst) begin
      if (mac_enable) n_en++;
      if (mac_clear) n_clr++;
      if (done) n_done++;
      if (in_valid && in_ready) n_hs++;
      if (in_ready && (!busy || out_valid || mac_enable || mac_clear)) n_perr++;
      if (done && !out_valid) n_perr++;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    logic [DW-1:0] exp;
    int tot[ELEMS];
    int nt, s, e, cyc, d0, c0, en0, h0, p0;
    bit hs, esat;
    nt = (v.ntf == 0) ? 1 : v.ntf;
    for (int t = 0; t < nt; t++)
      for (int i = 0; i < ELEMS; i++) begin
        ma[t][i] = v.akind ? int'($urandom_range(VMAX))
                           : ((i / M_SIZE == i % M_SIZE) ? 1 : 0);
        mb[t][i] = (v.bval < 0) ? int'($urandom_range(VMAX))
                                : ((v.bval + t * v.bstep) & VMAX);
      end
    esat = 1'b0;
    for (int i = 0; i < ELEMS; i++) tot[i] = 0;
    for (int t = 0; t < nt; t++)
      for (int r = 0; r < M_SIZE; r++)
        for (int c = 0; c < M_SIZE; c++) begin
          s = 0;
          for (int k = 0; k < M_SIZE; k++)
            s += ma[t][r*M_SIZE+k] * mb[t][k*M_SIZE+c];
          tot[r*M_SIZE+c] += s % (VMAX + 1);
        end
    for (int i = 0; i < ELEMS; i++) begin
      if (tot[i] > VMAX) esat = 1'b1;
`ifdef MMAC_SAT_EN
      exp[i*VW +: VW] = VW'((tot[i] > VMAX) ? VMAX : tot[i]);
`else
      exp[i*VW +: VW] = VW'(tot[i]);
`endif
      if (v.exp_lane >= 0) exp[i*VW +: VW] = VW'(v.exp_lane);
    end
    d0 = n_done; c0 = n_clr; en0 = n_en; h0 = n_hs; p0 = n_perr;

    @(posedge clk); #1;
    start = 1'b1;
    num_tiles = TILE_CW'(v.ntf);
    @(posedge clk); #1;
    start = 1'b0;
    num_tiles = TILE_CW'($urandom());
    e = 0;
    cyc = 0;
    while (e < ELEMS * nt && cyc < 3000) begin
      start = (v.bstart != 0 && cyc == 3);
      if (start) num_tiles = TILE_CW'(3);
      in_valid = ($urandom_range(99) >= v.gap);
      in_a = VW'(ma[e / ELEMS][e % ELEMS]);
      in_b = VW'(mb[e / ELEMS][e % ELEMS]);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) e++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (e < ELEMS * nt) check("load_timeout", DW'(e), DW'(ELEMS * nt));

    out_ready = (v.stall == 0);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check("out_timeout", DW'(out_valid), DW'(1));
    for (int k = 0; k < v.stall; k++) begin
      check("stall_data", out_data, exp);
      check("stall_done", DW'(done), DW'(0));
      check("stall_valid", DW'(out_valid), DW'(1));
      @(posedge clk); #1;
      if (k == v.stall - 1) out_ready = 1'b1;
      @(negedge clk);
    end
    check("out_data", out_data, exp);
    check("out_done", DW'(done), DW'(1));
`ifdef MMAC_SAT_EN
    check("sat_flag", DW'(sat_flag), DW'(esat));
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_after", DW'({busy, done, out_valid}), DW'(0));
    @(negedge clk);
    check("no_requeue", DW'(busy), DW'(0));
    check("done_cnt", DW'(n_done - d0), DW'(1));
    check("clear_cnt", DW'(n_clr - c0), DW'(1));
    check("enable_cnt", DW'(n_en - en0), DW'(nt));
    check("hs_cnt", DW'(n_hs - h0), DW'(ELEMS * nt));
    check("protocol", DW'(n_perr - p0), DW'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, DW'({busy, in_ready, mac_enable, mac_clear, out_valid, done}),
          DW'(0));
    check({name, "_a"}, mac_a, '0);
    check({name, "_b"}, mac_b, '0);
    check({name, "_out"}, out_data, '0);
  endtask

  vec_t tbl[8];
  vec_t v5;

  initial begin
    int h, cyc, d0;
    nvec = 0; nerr = 0;
    n_en = 0; n_clr = 0; n_done = 0; n_hs = 0; n_perr = 0;
    rst = 1'b0; start = 1'b0; num_tiles = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    tbl[0] = '{ntf: 1, akind: 0, bval: 3,   bstep: 0, gap: 0,  stall: 0, bstart: 0, exp_lane: 3};
    tbl[1] = '{ntf: 2, akind: 0, bval: 1,   bstep: 1, gap: 0,  stall: 0, bstart: 0, exp_lane: 3};
    tbl[2] = '{ntf: 1, akind: 0, bval: 7,   bstep: 0, gap: 50, stall: 5, bstart: 0, exp_lane: 7};
    tbl[3] = '{ntf: 0, akind: 0, bval: 9,   bstep: 0, gap: 0,  stall: 0, bstart: 1, exp_lane: 9};
    tbl[4] = '{ntf: 2, akind: 0, bval: 200, bstep: 0, gap: 0,  stall: 0, bstart: 0, exp_lane: 144};
    tbl[5] = '{ntf: 3, akind: 1, bval: -1,  bstep: 0, gap: 50, stall: 2, bstart: 0, exp_lane: -1};
    tbl[6] = '{ntf: 1, akind: 1, bval: -1,  bstep: 0, gap: 0,  stall: 0, bstart: 0, exp_lane: -1};
    tbl[7] = '{ntf: 4, akind: 1, bval: -1,  bstep: 0, gap: 30, stall: 1, bstart: 1, exp_lane: -1};
`ifdef MMAC_SAT_EN
    tbl[4].exp_lane = 255;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // Abort a job after 7 element handshakes
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1;
    num_tiles = TILE_CW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    h = 0;
    cyc = 0;
    while (h < 7 && cyc < 100) begin
      in_valid = 1'b1;
      in_a = VW'($urandom_range(1, VMAX));
      in_b = VW'($urandom_range(1, VMAX));
      @(negedge clk);
      if (in_ready) h++;
      @(posedge clk); #1;
      cyc++;
    end
    if (h < 7) check("abort_timeout", DW'(h), DW'(7));
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", DW'(busy), DW'(1));
    @(negedge clk);
    check_reset_outputs("abort_reset");
    @(negedge clk);
    check_reset_outputs("abort_reset2");
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_no_done", DW'(n_done - d0), DW'(0));
    v5 = '{ntf: 1, akind: 0, bval: 5, bstep: 0, gap: 0, stall: 0, bstart: 0, exp_lane: 5};
    run_job(v5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
